boa_branch_predictor: RTL

BOA_BRANCH_PREDICTOR -- requirements
Module: boa_branch_predictor

---
 rtl/boa_branch_predictor.sv | 70 +++++++
 1 files changed

// File: rtl/boa_branch_predictor.sv
// Conditional-branch direction predictor: static backward-taken, bimodal or gshare
// table of 2-bit saturating counters, plus a resolved-misprediction counter.
module boa_branch_predictor #(
  parameter int MODE      = 1,
  parameter int IDX_BITS  = 6,
  parameter int PERF_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lk_valid,
  input  logic [31:1]          lk_pc,
  input  logic [31:0]          lk_offset,
  output logic                 lk_predict,
  output logic [IDX_BITS-1:0]  lk_hist,
  input  logic                 up_valid,
  input  logic [31:1]          up_pc,
  input  logic [IDX_BITS-1:0]  up_hist,
  input  logic                 up_taken,
  input  logic                 up_predicted,
  output logic [PERF_BITS-1:0] perf_mispredict
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]           table_q [ENTRIES];
  logic [IDX_BITS-1:0]  ghr_q;
  logic [PERF_BITS-1:0] perf_q;
  logic [IDX_BITS-1:0]  lk_idx;
  logic [IDX_BITS-1:0]  up_idx;
  logic                 unused_ok;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'd3)
      nxt = ctr + 2'd1;
    else if (!taken && ctr != 2'd0)
      nxt = ctr - 2'd1;
    return nxt;
  endfunction

  // gshare folds the global history into both lookup and update indices
  assign lk_idx = (MODE == 2) ? (lk_pc[IDX_BITS:1] ^ ghr_q)   : lk_pc[IDX_BITS:1];
  assign up_idx = (MODE == 2) ? (up_pc[IDX_BITS:1] ^ up_hist) : up_pc[IDX_BITS:1];

  // Read is from registered state only: a same-cycle update is not bypassed
  assign lk_predict      = (MODE == 0) ? lk_offset[31] : table_q[lk_idx][1];
  assign lk_hist         = (MODE == 2) ? ghr_q : '0;
  assign perf_mispredict = perf_q;

  assign unused_ok = ^{lk_valid, lk_pc[31:IDX_BITS+1], up_pc[31:IDX_BITS+1],
                       up_hist, lk_offset[30:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++)
        table_q[i] <= 2'd1;
      ghr_q  <= '0;
      perf_q <= '0;
    end else if (up_valid) begin
      if (MODE != 0)
        table_q[up_idx] <= ctr_next(table_q[up_idx], up_taken);
      if (MODE == 2)
        ghr_q <= {ghr_q[IDX_BITS-2:0], up_taken};
      if (up_taken != up_predicted)
        perf_q <= perf_q + PERF_BITS'(1);
    end
  end

endmodule
